// File: rtl/cvm300_pixel_packer.sv
// cvm300_pixel_packer
// Packs the 8 MSBs of each qualified CVM300 pixel into 32-bit FIFO words
// (first pixel in [7:0]) and frames exactly one image per arm request.
//
// Ports
//   CVM300_CLK_OUT     pixel clock, all logic on its rising edge
//   wr_rst             async active-high reset, shared with FIFO write reset
//   arm                1 = capture one frame, 0 = abort / return to idle
//   CVM300_D           pixel data, only [9:2] used
//   CVM300_Data_valid  DVAL pixel qualifier
//   CVM300_Line_valid  LVAL line envelope
//   fifo_full          FIFO full flag
//   fifo_din           packed word (registered)
//   fifo_wr_en         one-cycle write strobe (registered)
//   busy               high in SYNC or CAPTURE
//   frame_done         high in DONE
//   overflow           sticky: word dropped on fifo_full
//   line_err           sticky: line ended with wrong pixel count
//   line_count         completed lines in this frame
//   word_count         words written in this frame (saturating)
//
// state   | meaning
// IDLE    | waiting for arm
// SYNC    | armed, waiting for LVAL low so capture starts on a line boundary
// CAPTURE | packing pixels, counting lines
// DONE    | frame complete, status held until arm drops

module cvm300_pixel_packer #(
   parameter int LINE_PIXELS = 648,
   parameter int FRAME_LINES = 488
) (
   input  logic        CVM300_CLK_OUT,
   input  logic        wr_rst,
   input  logic        arm,
   input  logic [9:0]  CVM300_D,
   input  logic        CVM300_Data_valid,
   input  logic        CVM300_Line_valid,
   input  logic        fifo_full,
   output logic [31:0] fifo_din,
   output logic        fifo_wr_en,
   output logic        busy,
   output logic        frame_done,
   output logic        overflow,
   output logic        line_err,
   output logic [9:0]  line_count,
   output logic [17:0] word_count
);

   typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, DONE} state_t;

   localparam logic [11:0] LP = 12'(LINE_PIXELS);
   localparam logic [9:0]  FL = 10'(FRAME_LINES);

   state_t      state_q, state_d;
   logic [1:0]  slot_q, slot_d;
   logic [31:0] word_q, word_d;
   logic [11:0] pix_cnt_q, pix_cnt_d;
   logic [9:0]  line_cnt_q, line_cnt_d;
   logic [17:0] word_cnt_q, word_cnt_d;
   logic        ovf_q, ovf_d;
   logic        lerr_q, lerr_d;
   logic [31:0] din_q, din_d;
   logic        wr_en_q, wr_en_d;
   logic        lval_q;

   logic        wr_try;
   logic [31:0] wr_word;
   logic [7:0]  pix;
   logic        unused_lsbs;

   assign pix         = CVM300_D[9:2];
   assign unused_lsbs = ^CVM300_D[1:0];

   always_ff @(posedge CVM300_CLK_OUT or posedge wr_rst) begin
      if (wr_rst) begin
         state_q    <= IDLE;
         slot_q     <= 2'd0;
         word_q     <= '0;
         pix_cnt_q  <= '0;
         line_cnt_q <= '0;
         word_cnt_q <= '0;
         ovf_q      <= 1'b0;
         lerr_q     <= 1'b0;
         din_q      <= '0;
         wr_en_q    <= 1'b0;
         lval_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         word_q     <= word_d;
         pix_cnt_q  <= pix_cnt_d;
         line_cnt_q <= line_cnt_d;
         word_cnt_q <= word_cnt_d;
         ovf_q      <= ovf_d;
         lerr_q     <= lerr_d;
         din_q      <= din_d;
         wr_en_q    <= wr_en_d;
         lval_q     <= CVM300_Line_valid;
      end
   end

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      word_d     = word_q;
      pix_cnt_d  = pix_cnt_q;
      line_cnt_d = line_cnt_q;
      word_cnt_d = word_cnt_q;
      ovf_d      = ovf_q;
      lerr_d     = lerr_q;
      din_d      = din_q;
      wr_en_d    = 1'b0;
      wr_try     = 1'b0;
      wr_word    = '0;

      case (state_q)
         IDLE: begin
            if (arm) begin
               slot_d     = 2'd0;
               word_d     = '0;
               pix_cnt_d  = '0;
               line_cnt_d = '0;
               word_cnt_d = '0;
               ovf_d      = 1'b0;
               lerr_d     = 1'b0;
               state_d    = SYNC;
            end
         end
         SYNC: begin
            if (!arm)                    state_d = IDLE;
            else if (!CVM300_Line_valid) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (!arm) begin
               // abort: partial word discarded, counters/flags left for readout
               slot_d  = 2'd0;
               word_d  = '0;
               state_d = IDLE;
            end else if (lval_q && !CVM300_Line_valid) begin
               if (slot_q != 2'd0) begin
                  wr_try  = 1'b1;
                  wr_word = word_q;   // unused upper lanes are already zero
               end
               slot_d     = 2'd0;
               word_d     = '0;
               if (pix_cnt_q != LP) lerr_d = 1'b1;
               pix_cnt_d  = '0;
               line_cnt_d = line_cnt_q + 10'd1;
               if (line_cnt_d == FL) state_d = DONE;
            end else if (CVM300_Data_valid && CVM300_Line_valid) begin
               if (pix_cnt_q != 12'hfff) pix_cnt_d = pix_cnt_q + 12'd1;
               if (slot_q == 2'd3) begin
                  wr_try  = 1'b1;
                  wr_word = {pix, word_q[23:0]};
                  slot_d  = 2'd0;
                  word_d  = '0;
               end else begin
                  word_d[{slot_q, 3'b000} +: 8] = pix;
                  slot_d = slot_q + 2'd1;
               end
            end
         end
         DONE: begin
            if (!arm) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (wr_try) begin
         if (fifo_full) begin
            ovf_d = 1'b1;
         end else begin
            wr_en_d = 1'b1;
            din_d   = wr_word;
            if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 18'd1;
         end
      end
   end

   assign fifo_din   = din_q;
   assign fifo_wr_en = wr_en_q;
   assign busy       = (state_q == SYNC) || (state_q == CAPTURE);
   assign frame_done = (state_q == DONE);
   assign overflow   = ovf_q;
   assign line_err   = lerr_q;
   assign line_count = line_cnt_q;
   assign word_count = word_cnt_q;

endmodule

// File: tb/tb_cvm300_pixel_packer.sv
module tb_cvm300_pixel_packer;

   logic        clk = 1'b0;
   logic        wr_rst;
   logic        arm;
   logic [9:0]  d;
   logic        dval;
   logic        lval;
   logic        fifo_full;
   logic [31:0] fifo_din;
   logic        fifo_wr_en;
   logic        busy;
   logic        frame_done;
   logic        overflow;
   logic        line_err;
   logic [9:0]  line_count;
   logic [17:0] word_count;

   int total = 0;
   int bad   = 0;
   logic [31:0] got_q[$];

   cvm300_pixel_packer #(.LINE_PIXELS(8), .FRAME_LINES(2)) dut (
      .CVM300_CLK_OUT   (clk),
      .wr_rst           (wr_rst),
      .arm              (arm),
      .CVM300_D         (d),
      .CVM300_Data_valid(dval),
      .CVM300_Line_valid(lval),
      .fifo_full        (fifo_full),
      .fifo_din         (fifo_din),
      .fifo_wr_en       (fifo_wr_en),
      .busy             (busy),
      .frame_done       (frame_done),
      .overflow         (overflow),
      .line_err         (line_err),
      .line_count       (line_count),
      .word_count       (word_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (fifo_wr_en) got_q.push_back(fifo_din);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // pixel i carries 4*(i+1) in [9:2]; bits [1:0] set to prove they are dropped
   task automatic send_line(input int n, input logic [15:0] full_mask);
      for (int i = 0; i < n; i++) begin
         lval = 1'b1; dval = 1'b1; fifo_full = full_mask[i];
         d = {8'(4 * (i + 1)), 2'b11};
         step(1);
      end
      lval = 1'b0; dval = 1'b0; fifo_full = 1'b0; d = '0;
      step(3);
   endtask

   task automatic chk_words(input string tag, input logic [31:0] exp[$]);
      chk({tag, "_nwords"}, 32'(got_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < got_q.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), got_q[i], exp[i]);
      got_q.delete();
   endtask

   task automatic chk_status(input string tag, input int wc, input int lc,
                             input logic fd, input logic ov, input logic le);
      chk({tag, "_word_count"}, 32'(word_count), 32'(wc));
      chk({tag, "_line_count"}, 32'(line_count), 32'(lc));
      chk({tag, "_frame_done"}, 32'(frame_done), 32'(fd));
      chk({tag, "_overflow"},   32'(overflow),   32'(ov));
      chk({tag, "_line_err"},   32'(line_err),   32'(le));
   endtask

   task automatic arm_and_sync();
      arm = 1'b1;
      step(3);
   endtask

   initial begin
      logic [31:0] exp_q[$];
      wr_rst = 1'b1; arm = 1'b0; d = '0; dval = 1'b0; lval = 1'b0; fifo_full = 1'b0;
      #2;
      chk("rst_din",   fifo_din, 32'h0);
      chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk_status("rst", 0, 0, 1'b0, 1'b0, 1'b0);
      step(2);
      wr_rst = 1'b0;
      step(2);

      // full frame
      arm_and_sync();
      chk("t1_busy", 32'(busy), 32'h1);
      send_line(8, 16'h0);
      chk("t1_busy_mid", 32'(busy), 32'h1);
      chk("t1_lc_mid", 32'(line_count), 32'd1);
      send_line(8, 16'h0);
      chk("t1_busy_end", 32'(busy), 32'h0);
      exp_q = '{32'h100C0804, 32'h201C1814, 32'h100C0804, 32'h201C1814};
      chk_words("t1", exp_q);
      chk_status("t1", 4, 2, 1'b1, 1'b0, 1'b0);
      send_line(8, 16'h0);   // ignored in DONE
      exp_q = '{};
      chk_words("t1_done", exp_q);
      chk_status("t1_done", 4, 2, 1'b1, 1'b0, 1'b0);

      // arm mid-line
      arm = 1'b0;
      step(1);
      lval = 1'b1; dval = 1'b1; d = {8'hAA, 2'b00};
      step(3);
      arm = 1'b1;
      step(5);
      lval = 1'b0; dval = 1'b0; d = '0;
      step(3);
      send_line(8, 16'h0);
      send_line(8, 16'h0);
      exp_q = '{32'h100C0804, 32'h201C1814, 32'h100C0804, 32'h201C1814};
      chk_words("t2", exp_q);
      chk_status("t2", 4, 2, 1'b1, 1'b0, 1'b0);

      // short line
      arm = 1'b0;
      step(1);
      arm_and_sync();
      send_line(6, 16'h0);
      chk("t3_lerr_mid", 32'(line_err), 32'h1);
      send_line(8, 16'h0);
      exp_q = '{32'h100C0804, 32'h00001814, 32'h100C0804, 32'h201C1814};
      chk_words("t3", exp_q);
      chk_status("t3", 4, 2, 1'b1, 1'b0, 1'b1);

      // fifo_full on the second word of line 0
      arm = 1'b0;
      step(1);
      arm_and_sync();
      chk("t4_lerr_cleared", 32'(line_err), 32'h0);
      send_line(8, 16'h0080);
      send_line(8, 16'h0);
      exp_q = '{32'h100C0804, 32'h100C0804, 32'h201C1814};
      chk_words("t4", exp_q);
      chk_status("t4", 3, 2, 1'b1, 1'b1, 1'b0);

      // abort mid-line
      arm = 1'b0;
      step(1);
      arm_and_sync();
      chk_status("t5_rearm", 0, 0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         lval = 1'b1; dval = 1'b1; d = {8'(4 * (i + 1)), 2'b00};
         step(1);
      end
      arm = 1'b0;
      d = {8'h77, 2'b00};
      step(1);
      chk("t5_busy", 32'(busy), 32'h0);
      lval = 1'b0; dval = 1'b0; d = '0;
      step(3);
      exp_q = '{32'h100C0804};
      chk_words("t5", exp_q);
      chk_status("t5", 1, 0, 1'b0, 1'b0, 1'b0);
      arm = 1'b1;
      step(1);
      chk("t5_wc_cleared", 32'(word_count), 32'h0);
      step(2);

      // async reset mid-word
      send_line(8, 16'h0);
      for (int i = 0; i < 2; i++) begin
         lval = 1'b1; dval = 1'b1; d = {8'hEE, 2'b00};
         step(1);
      end
      lval = 1'b0; dval = 1'b0; d = '0; arm = 1'b0;
      #2 wr_rst = 1'b1;
      #1;
      chk("t6_din",   fifo_din, 32'h0);
      chk("t6_busy",  32'(busy), 32'h0);
      chk_status("t6", 0, 0, 1'b0, 1'b0, 1'b0);
      #2 wr_rst = 1'b0;
      step(2);
      got_q.delete();
      arm_and_sync();
      send_line(8, 16'h0);
      exp_q = '{32'h100C0804, 32'h201C1814};
      chk_words("t6_after", exp_q);
      chk_status("t6_after", 2, 1, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
